// File: rtl/add_sub_serial.sv
// Slice-serial adder/subtractor: CHUNK bits per cycle, LSB first, start/ready in, valid pulse out.
// Optional ADD_SUB_SERIAL_SAT_EN adds sat_i, which clamps the result on signed overflow.
module add_sub_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
`ifdef ADD_SUB_SERIAL_SAT_EN
  input  logic             sat_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] r_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             overflow_o
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastSlice = CW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_cy;
  logic             r_zacc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_zero;
  logic             r_ovf;
  logic             r_valid;
`ifdef ADD_SUB_SERIAL_SAT_EN
  logic             r_sat;
`endif

  logic [CHUNK:0]   w_slice;
  logic [CHUNK-1:0] w_s;
  logic             w_c;
  logic [IW-1:0]    w_base;
  logic [WIDTH-1:0] w_res;
  logic             w_zero;
  logic             w_ovf;
  logic             w_last;
  logic [WIDTH-1:0] w_out;
  logic             w_out_zero;

  // Operands shift right each slice, so the current slice always sits in the low CHUNK bits.
  assign w_slice = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_cy};
  assign w_s     = w_slice[CHUNK-1:0];
  assign w_c     = w_slice[CHUNK];
  assign w_base  = IW'(r_cnt * CHUNK);
  assign w_zero  = r_zacc & (w_s == '0);
  assign w_ovf   = (r_a[CHUNK-1] == r_b[CHUNK-1]) && (w_s[CHUNK-1] != r_a[CHUNK-1]);
  assign w_last  = (r_cnt == LastSlice);

  always_comb begin
    w_res = r_acc;
    w_res[w_base +: CHUNK] = w_s;
  end

`ifdef ADD_SUB_SERIAL_SAT_EN
  always_comb begin
    w_out      = w_res;
    w_out_zero = w_zero;
    if (r_sat && w_ovf) begin
      w_out      = r_a[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      w_out_zero = 1'b0;
    end
  end
`else
  assign w_out      = w_res;
  assign w_out_zero = w_zero;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cy    <= 1'b0;
      r_zacc  <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
`ifdef ADD_SUB_SERIAL_SAT_EN
      r_sat   <= 1'b0;
`endif
    end else begin
      case (r_state)
        StIdle, StDone: begin
          r_valid <= 1'b0;
          if (start_i) begin
            r_a     <= a_i;
            r_b     <= b_i ^ {WIDTH{sub_i}};
            r_cy    <= sub_i;
            r_zacc  <= 1'b1;
            r_cnt   <= '0;
            r_acc   <= '0;
`ifdef ADD_SUB_SERIAL_SAT_EN
            r_sat   <= sat_i;
`endif
            r_state <= StRun;
          end
        end
        StRun: begin
          r_a    <= r_a >> CHUNK;
          r_b    <= r_b >> CHUNK;
          r_cy   <= w_c;
          r_zacc <= w_zero;
          r_acc  <= w_res;
          r_cnt  <= r_cnt + 1'b1;
          // Visible outputs change only here, so a partial sum is never exposed.
          if (w_last) begin
            r_res   <= w_out;
            r_carry <= w_c;
            r_zero  <= w_out_zero;
            r_ovf   <= w_ovf;
            r_valid <= 1'b1;
            r_state <= StDone;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ready_o    = (r_state != StRun);
  assign valid_o    = r_valid;
  assign r_o        = r_res;
  assign carry_o    = r_carry;
  assign zero_o     = r_zero;
  assign overflow_o = r_ovf;

endmodule

// File: tb/tb_add_sub_serial.sv
// Directed bench for add_sub_serial: an 8-bit-slice instance and a single-slice instance.
// Saturation vectors run only when ADD_SUB_SERIAL_SAT_EN is defined.
module tb_add_sub_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0;
  logic        start1;
  logic        sub;
  logic        sat;
  logic [31:0] a;
  logic [31:0] b;

  logic        rdy0, vld0, cy0, z0, ov0;
  logic [31:0] r0;
  logic        rdy1, vld1, cy1, z1, ov1;
  logic [31:0] r1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_sub_serial #(.WIDTH(32), .CHUNK(8)) u_dut0 (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start0),
    .sub_i      (sub),
`ifdef ADD_SUB_SERIAL_SAT_EN
    .sat_i      (sat),
`endif
    .a_i        (a),
    .b_i        (b),
    .ready_o    (rdy0),
    .valid_o    (vld0),
    .r_o        (r0),
    .carry_o    (cy0),
    .zero_o     (z0),
    .overflow_o (ov0)
  );

  add_sub_serial #(.WIDTH(32), .CHUNK(32)) u_dut1 (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start1),
    .sub_i      (sub),
`ifdef ADD_SUB_SERIAL_SAT_EN
    .sat_i      (sat),
`endif
    .a_i        (a),
    .b_i        (b),
    .ready_o    (rdy1),
    .valid_o    (vld1),
    .r_o        (r1),
    .carry_o    (cy1),
    .zero_o     (z1),
    .overflow_o (ov1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the cycle following the valid pulse.
  task automatic do_op(input string tag, input bit sel, input logic [31:0] ta,
                       input logic [31:0] tb, input logic tsub, input logic tsat,
                       input logic [31:0] er, input logic ec, input logic ez,
                       input logic ev, input int elat);
    int   lat;
    logic seen;
    a   = ta;
    b   = tb;
    sub = tsub;
    sat = tsat;
    if (sel) start1 = 1'b1;
    else     start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    a   = ~ta;
    b   = 32'h5A5A_A5A5;
    sub = ~tsub;
    sat = ~tsat;
    check({tag, "_busy"}, {31'd0, sel ? rdy1 : rdy0}, 32'd0);
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat  = i;
      seen = sel ? vld1 : vld0;
    end
    check({tag, "_lat"}, lat, elat);
    check({tag, "_r"}, sel ? r1 : r0, er);
    check({tag, "_c"}, {31'd0, sel ? cy1 : cy0}, {31'd0, ec});
    check({tag, "_z"}, {31'd0, sel ? z1 : z0}, {31'd0, ez});
    check({tag, "_v"}, {31'd0, sel ? ov1 : ov0}, {31'd0, ev});
    check({tag, "_rdy"}, {31'd0, sel ? rdy1 : rdy0}, 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, {31'd0, sel ? vld1 : vld0}, 32'd0);
    check({tag, "_hold"}, sel ? r1 : r0, er);
  endtask

  initial begin
    int nv;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; sub = 1'b0; sat = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", {31'd0, rdy0}, 32'd1);
    check("rst_vld", {31'd0, vld0}, 32'd0);
    check("rst_r", r0, 32'd0);
    check("rst_flags", {29'd0, cy0, z0, ov0}, 32'd0);

    // Reset wins over a simultaneous start.
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    rst    = 1'b0;
    check("rst_wins", {31'd0, rdy0}, 32'd1);

    do_op("t1_wrap", 0, 32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0, 1, 1, 0, 4);
    do_op("t2_neg", 0, 32'd5, 32'd7, 1, 0, 32'hFFFF_FFFE, 0, 0, 0, 4);
    do_op("t2_eq", 0, 32'd7, 32'd7, 1, 0, 32'h0, 1, 1, 0, 4);
    do_op("t3_povf", 0, 32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 0, 0, 1, 4);
    do_op("t3_novf", 0, 32'h8000_0000, 32'h1, 1, 0, 32'h7FFF_FFFF, 1, 0, 1, 4);
    do_op("zacc_mid", 0, 32'h0001_0000, 32'h0, 0, 0, 32'h0001_0000, 0, 0, 0, 4);
    do_op("zacc_cy", 0, 32'h0000_0100, 32'hFFFF_FF00, 0, 0, 32'h0, 1, 1, 0, 4);
    do_op("mix", 0, 32'h1234_5678, 32'h0FED_CBA9, 0, 0, 32'h2222_2221, 0, 0, 0, 4);
`ifdef ADD_SUB_SERIAL_SAT_EN
    do_op("sat_pos", 0, 32'h7FFF_FFFF, 32'h1, 0, 1, 32'h7FFF_FFFF, 0, 0, 1, 4);
    do_op("sat_neg", 0, 32'h8000_0000, 32'h1, 1, 1, 32'h8000_0000, 1, 0, 1, 4);
    do_op("sat_none", 0, 32'd5, 32'd7, 1, 1, 32'hFFFF_FFFE, 0, 0, 0, 4);
`endif

    // Back-to-back: start held through RUN and into the valid cycle.
    a = 32'h10; b = 32'h20; sub = 1'b0; start0 = 1'b1;
    @(posedge clk);
    #1;
    a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b1;
    nv = 0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 4) nv += int'(vld0);
    end
    check("b2b_early", nv, 0);
    check("b2b_v1", {31'd0, vld0}, 32'd1);
    check("b2b_r1", r0, 32'h30);
    @(posedge clk);
    #1;
    start0 = 1'b0;
    check("b2b_acc2", {31'd0, rdy0}, 32'd0);
    check("b2b_hold1", r0, 32'h30);
    nv = 0;
    for (int i = 1; i <= 20 && !vld0; i++) begin
      @(posedge clk);
      #1;
      nv = i;
    end
    check("b2b_lat2", nv, 4);
    check("b2b_r2", r0, 32'h0123_4567);
    check("b2b_c2", {31'd0, cy0}, 32'd1);

    // Reset while slice 2 is being processed.
    a = 32'h0F0F_0F0F; b = 32'h0101_0101; sub = 1'b0; start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rdy", {31'd0, rdy0}, 32'd1);
    check("mid_r", r0, 32'd0);
    check("mid_flags", {28'd0, vld0, cy0, z0, ov0}, 32'd0);
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      nv += int'(vld0);
    end
    check("mid_novld", nv, 0);
    do_op("mid_after", 0, 32'h0F0F_0F0F, 32'h0101_0101, 0, 0, 32'h1010_1010, 0, 0, 0, 4);

    // Single-slice instance.
    do_op("t6_ovf", 1, 32'h8000_0000, 32'h8000_0000, 0, 0, 32'h0, 1, 1, 1, 1);
    do_op("t6_sub", 1, 32'd5, 32'd7, 1, 0, 32'hFFFF_FFFE, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
